cordic_seq: RTL

CORDIC_SEQ -- requirements
Module: cordic_seq

---
 rtl/cordic_pkg.sv | 51 +++++
 rtl/cordic_update.sv | 34 +++
 rtl/cordic_seq.sv | 109 ++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared constants, FSM state encoding and arctangent lookup for the sequential CORDIC.
package cordic_pkg;

  localparam logic [31:0] K_INIT  = 32'h26DD3B6A;
  localparam logic [31:0] QUARTER = 32'h40000000;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

  // atan(2^-i) scaled so that 2^32 is a full circle
  function automatic logic [31:0] atan_lut(input logic [4:0] idx);
    logic [31:0] v;
    case (idx)
      5'd0:  v = 32'h20000000;
      5'd1:  v = 32'h12E4051E;
      5'd2:  v = 32'h09FB385B;
      5'd3:  v = 32'h051111D4;
      5'd4:  v = 32'h028B0D43;
      5'd5:  v = 32'h0145D7E1;
      5'd6:  v = 32'h00A2F61E;
      5'd7:  v = 32'h00517C55;
      5'd8:  v = 32'h0028BE53;
      5'd9:  v = 32'h00145F2F;
      5'd10: v = 32'h000A2F98;
      5'd11: v = 32'h000517CC;
      5'd12: v = 32'h00028BE6;
      5'd13: v = 32'h000145F3;
      5'd14: v = 32'h0000A2FA;
      5'd15: v = 32'h0000517D;
      5'd16: v = 32'h000028BE;
      5'd17: v = 32'h0000145F;
      5'd18: v = 32'h00000A30;
      5'd19: v = 32'h00000518;
      5'd20: v = 32'h0000028C;
      5'd21: v = 32'h00000146;
      5'd22: v = 32'h000000A3;
      5'd23: v = 32'h00000051;
      5'd24: v = 32'h00000029;
      5'd25: v = 32'h00000014;
      5'd26: v = 32'h0000000A;
      5'd27: v = 32'h00000005;
      5'd28: v = 32'h00000003;
      5'd29: v = 32'h00000001;
      5'd30: v = 32'h00000001;
      default: v = 32'h00000000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cordic_update.sv
// One combinational CORDIC micro-rotation in rotation mode, direction chosen by the sign of z.
module cordic_update
  import cordic_pkg::*;
(
  input  logic signed [31:0] x,
  input  logic signed [31:0] y,
  input  logic signed [31:0] z,
  input  logic        [5:0]  shift,
  input  logic signed [31:0] atan,
  output logic signed [31:0] x_next,
  output logic signed [31:0] y_next,
  output logic signed [31:0] z_next
);

  logic signed [31:0] x_sh;
  logic signed [31:0] y_sh;

  assign x_sh = x >>> shift;
  assign y_sh = y >>> shift;

  // All sums wrap in 32 bits; no saturation.
  always_comb begin
    if (!z[31]) begin
      x_next = x - y_sh;
      y_next = y + x_sh;
      z_next = z - atan;
    end else begin
      x_next = x + y_sh;
      y_next = y - x_sh;
      z_next = z + atan;
    end
  end

endmodule

// File: rtl/cordic_seq.sv
// Iterative CORDIC sine/cosine, one micro-rotation per clock, ITER rotations per result.
// Define CORDIC_QUAD_EN to add quadrant pre-rotation for full-circle angle inputs.
module cordic_seq
  import cordic_pkg::*;
#(
  parameter int ITER = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] angle,
  output logic        busy,
  output logic        done,
  output logic [31:0] cos_out,
  output logic [31:0] sin_out
);

  localparam logic [4:0] LAST_I = 5'(ITER - 1);

  state_t             state;
  logic        [4:0]  i;
  logic signed [31:0] x;
  logic signed [31:0] y;
  logic signed [31:0] z;
  logic signed [31:0] x0;
  logic signed [31:0] y0;
  logic signed [31:0] z0;
  logic signed [31:0] x_next;
  logic signed [31:0] y_next;
  logic signed [31:0] z_next;

`ifdef CORDIC_QUAD_EN
  // Fold the second and third quadrants onto +/-90 deg so the rotation stays in range.
  always_comb begin
    x0 = K_INIT;
    y0 = '0;
    z0 = angle;
    case (angle[31:30])
      2'b01: begin
        x0 = '0;
        y0 = K_INIT;
        z0 = angle - QUARTER;
      end
      2'b10: begin
        x0 = '0;
        y0 = 32'd0 - K_INIT;
        z0 = angle + QUARTER;
      end
      default: ;
    endcase
  end
`else
  always_comb begin
    x0 = K_INIT;
    y0 = '0;
    z0 = angle;
  end
`endif

  cordic_update u_update (
    .x      (x),
    .y      (y),
    .z      (z),
    .shift  ({1'b0, i}),
    .atan   (atan_lut(i)),
    .x_next (x_next),
    .y_next (y_next),
    .z_next (z_next)
  );

  assign busy = (state == ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      i       <= '0;
      x       <= '0;
      y       <= '0;
      z       <= '0;
      done    <= 1'b0;
      cos_out <= '0;
      sin_out <= '0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        if (start) begin
          x     <= x0;
          y     <= y0;
          z     <= z0;
          i     <= '0;
          state <= ST_RUN;
        end
      end else begin
        x <= x_next;
        y <= y_next;
        z <= z_next;
        i <= i + 5'd1;
        // Final rotation publishes straight from the update stage.
        if (i == LAST_I) begin
          cos_out <= x_next;
          sin_out <= y_next;
          done    <= 1'b1;
          state   <= ST_IDLE;
        end
      end
    end
  end

endmodule
